// File: rtl/eau_mc_pkg.sv
// Shared geometry, types and helpers for the multi-channel element alignment unit.
package eau_mc_pkg;

   localparam int unsigned VLEN = 256;
   localparam int unsigned BSW  = 5;
   localparam int unsigned BS   = 1 << BSW;
   localparam int unsigned BLEN = VLEN / BS;
   localparam int unsigned WW   = 8 - BSW + 1;
   // Slot offsets: P stays <= BS for packed elements, P+L needs one more bit.
   localparam int unsigned PW   = BSW + 2;

   typedef logic [BLEN-1:0] blk_t;
   typedef logic [WW-1:0]   len_t;
   typedef logic [BSW-1:0]  pos_t;
   typedef logic [BSW:0]    num_t;
   typedef logic [PW-1:0]   pfx_t;

   function automatic num_t min_num(input num_t a, input num_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/eau_mc_if.sv
// Beat interface of the element alignment unit: input beat, output beat, valid/ready on each.
interface eau_mc_if #(
   parameter int unsigned NCH = 2
) ();
   import eau_mc_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   num_t [NCH-1:0]          inum;
   len_t [NCH-1:0][BS-1:0]  ilen;
   pos_t [NCH-1:0][BS-1:0]  ipos;
   blk_t [NCH-1:0][BS-1:0]  idata;

   logic                    out_valid;
   logic                    out_ready;
   num_t                    onum;
   logic                    otrunc;
   blk_t [NCH-1:0][BS-1:0]  odata;

   modport master (
      output in_valid, inum, ilen, ipos, idata, out_ready,
      input  in_ready, out_valid, onum, otrunc, odata
   );

   modport slave (
      input  in_valid, inum, ilen, ipos, idata, out_ready,
      output in_ready, out_valid, onum, otrunc, odata
   );
endinterface

// File: rtl/eau_mc_lane.sv
// One channel's slot gather: each output slot pulls its source block or a pad block.
// With EAU_MC_SIGNEXT_EN defined, pads replicate the MSB of the element's last real block.
module eau_mc_lane import eau_mc_pkg::*; (
   input  len_t [BS-1:0] clen_i,
   input  pos_t [BS-1:0] pos_i,
   input  blk_t [BS-1:0] data_i,
   input  len_t [BS-1:0] elen_i,
   input  pfx_t [BS-1:0] pfx_i,
   output blk_t [BS-1:0] odata_o
);

   pfx_t slot;
   pfx_t off;
   pos_t src;
   blk_t pad;
`ifdef EAU_MC_SIGNEXT_EN
   pos_t last;
`endif

   // elen_i is zero for elements beyond onum, so their slot range is empty.
   always_comb begin
      odata_o = '0;
      slot    = '0;
      off     = '0;
      src     = '0;
      pad     = '0;
`ifdef EAU_MC_SIGNEXT_EN
      last    = '0;
`endif
      for (int i = 0; i < BS; i++) begin
         slot = pfx_t'(i);
         for (int e = 0; e < BS; e++) begin
            off = slot - pfx_i[e];
            src = pos_i[e] + pos_t'(off);
`ifdef EAU_MC_SIGNEXT_EN
            last = pos_i[e] + pos_t'(clen_i[e]) - pos_t'(1);
            pad  = (clen_i[e] != '0) ? {BLEN{data_i[last][BLEN-1]}} : '0;
`else
            pad  = '0;
`endif
            if (slot >= pfx_i[e] && slot < pfx_i[e] + pfx_t'(elen_i[e])) begin
               odata_o[i] = (off < pfx_t'(clen_i[e])) ? data_i[src] : pad;
            end
         end
      end
   end

endmodule

// File: rtl/eau_mc.sv
// Element alignment unit: S1 computes common widths/offsets, S2 gathers per-channel slots.
// Pad style selected by EAU_MC_SIGNEXT_EN (see eau_mc_lane).
module eau_mc import eau_mc_pkg::*; #(
   parameter int unsigned NCH = 2
) (
   input logic     clk,
   input logic     rst,
   eau_mc_if.slave bus
);

   typedef logic [PW+WW-1:0] wsum_t;

   logic s1_valid_q, s2_valid_q, s2_rdy;

   // S1 combinational
   num_t            n;
   len_t [BS-1:0]   lmax;
   wsum_t           psum [BS+1];
   num_t            onum_d;
   logic            otrunc_d;
   len_t [BS-1:0]   elen_d;
   pfx_t [BS-1:0]   pfx_d;

   // S1 registers
   num_t                    s1_onum_q;
   logic                    s1_otrunc_q;
   len_t [BS-1:0]           elen_q;
   pfx_t [BS-1:0]           pfx_q;
   len_t [NCH-1:0][BS-1:0]  ilen_q;
   pos_t [NCH-1:0][BS-1:0]  ipos_q;
   blk_t [NCH-1:0][BS-1:0]  idata_q;

   // S2
   blk_t [NCH-1:0][BS-1:0]  lane_out;
   num_t                    s2_onum_q;
   logic                    s2_otrunc_q;
   blk_t [NCH-1:0][BS-1:0]  odata_q;

   assign s2_rdy       = !s2_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_rdy;

   always_comb begin
      n = bus.inum[0];
      for (int c = 1; c < NCH; c++) n = min_num(n, bus.inum[c]);
      for (int e = 0; e < BS; e++) begin
         lmax[e] = '0;
         if (num_t'(e) < n) begin
            for (int c = 0; c < NCH; c++) begin
               if (bus.ilen[c][e] > lmax[e]) lmax[e] = bus.ilen[c][e];
            end
         end
      end
      // Wide sums so an oversubscribed beat never wraps back under BS.
      psum[0] = '0;
      for (int e = 0; e < BS; e++) psum[e+1] = psum[e] + wsum_t'(lmax[e]);
      onum_d = '0;
      for (int k = 1; k <= BS; k++) begin
         if (num_t'(k) <= n && psum[k] <= wsum_t'(BS)) onum_d = num_t'(k);
      end
      otrunc_d = (onum_d != n);
      for (int e = 0; e < BS; e++) begin
         elen_d[e] = (num_t'(e) < onum_d) ? lmax[e] : '0;
         pfx_d[e]  = pfx_t'(psum[e]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid_q <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid && bus.in_ready) begin
         s1_onum_q   <= onum_d;
         s1_otrunc_q <= otrunc_d;
         elen_q      <= elen_d;
         pfx_q       <= pfx_d;
         ilen_q      <= bus.ilen;
         ipos_q      <= bus.ipos;
         idata_q     <= bus.idata;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      eau_mc_lane u_lane (
         .clen_i  (ilen_q[c]),
         .pos_i   (ipos_q[c]),
         .data_i  (idata_q[c]),
         .elen_i  (elen_q),
         .pfx_i   (pfx_q),
         .odata_o (lane_out[c])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q  <= 1'b0;
         s2_onum_q   <= '0;
         s2_otrunc_q <= 1'b0;
         odata_q     <= '0;
      end else if (s2_rdy) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_onum_q   <= s1_onum_q;
            s2_otrunc_q <= s1_otrunc_q;
            odata_q     <= lane_out;
         end
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.onum      = s2_onum_q;
   assign bus.otrunc    = s2_otrunc_q;
   assign bus.odata     = odata_q;

endmodule

// File: tb/tb_eau_mc.sv
// Bench for eau_mc: directed vector table, reset/flush sequence, and streamed random beats
// checked against a slot-scatter reference model.
module tb_eau_mc;
   import eau_mc_pkg::*;

   localparam int unsigned NCH = 2;
`ifdef EAU_MC_SIGNEXT_EN
   localparam bit SIGNEXT = 1'b1;
`else
   localparam bit SIGNEXT = 1'b0;
`endif

   typedef blk_t [NCH-1:0][BS-1:0] data_t;
   typedef struct {
      num_t [NCH-1:0]         inum;
      len_t [NCH-1:0][BS-1:0] ilen;
      pos_t [NCH-1:0][BS-1:0] ipos;
      data_t                  idata;
   } beat_t;
   typedef struct {
      int    onum;
      bit    otrunc;
      data_t odata;
   } exp_t;
   typedef struct {
      string name;
      beat_t b;
      int    onum;
      bit    otrunc;
      int    ch;
      int    slot;
      int    val;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eau_mc_if #(.NCH(NCH)) bus ();
   eau_mc #(.NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   vec_t vt[8];

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic blk_t pad_of(input beat_t b, input int c, input int e);
      int lastb;
      if (!SIGNEXT || b.ilen[c][e] == 0) return '0;
      lastb = (int'(b.ipos[c][e]) + int'(b.ilen[c][e]) - 1) % BS;
      return b.idata[c][lastb][BLEN-1] ? '1 : '0;
   endfunction

   // Walk elements in order, placing each at the running offset until the vector is full.
   function automatic exp_t model(input beat_t b);
      exp_t x;
      int n, p, k;
      int lw[BS];
      n = b.inum[0];
      for (int c = 1; c < NCH; c++) if (b.inum[c] < n) n = b.inum[c];
      for (int e = 0; e < BS; e++) begin
         lw[e] = 0;
         if (e < n) for (int c = 0; c < NCH; c++) if (b.ilen[c][e] > lw[e]) lw[e] = b.ilen[c][e];
      end
      x.odata = '0;
      p = 0;
      k = 0;
      while (k < n && p + lw[k] <= BS) begin
         for (int off = 0; off < lw[k]; off++) begin
            for (int c = 0; c < NCH; c++) begin
               if (off < b.ilen[c][k]) x.odata[c][p+off] = b.idata[c][(b.ipos[c][k] + off) % BS];
               else x.odata[c][p+off] = pad_of(b, c, k);
            end
         end
         p += lw[k];
         k++;
      end
      x.onum   = k;
      x.otrunc = (k != n);
      return x;
   endfunction

   // Lengths for elements 0..3 come as nibbles (element 0 in bits 3:0); the rest use dl.
   function automatic beat_t mk(input int n0, input int n1, input logic [15:0] l0,
                                input logic [15:0] l1, input int dl);
      beat_t b;
      int p, len;
      b.inum[0] = num_t'(n0);
      b.inum[1] = num_t'(n1);
      for (int c = 0; c < NCH; c++) begin
         p = 0;
         for (int e = 0; e < BS; e++) begin
            if (e < 4) len = (c == 0) ? int'(l0[e*4 +: 4]) : int'(l1[e*4 +: 4]);
            else len = dl;
            b.ilen[c][e]  = len_t'(len);
            b.ipos[c][e]  = pos_t'(p % BS);
            b.idata[c][e] = blk_t'(c * 64 + e + 1);
            p += len;
         end
      end
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      int mx;
      mx = ($urandom % 4 == 0) ? 15 : 3;
      for (int c = 0; c < NCH; c++) begin
         b.inum[c] = num_t'($urandom_range(0, BS));
         for (int e = 0; e < BS; e++) begin
            b.ilen[c][e]  = len_t'($urandom_range(0, mx));
            b.ipos[c][e]  = pos_t'($urandom);
            b.idata[c][e] = blk_t'($urandom);
         end
      end
      return b;
   endfunction

   task automatic drive(input beat_t b);
      bus.inum  = b.inum;
      bus.ilen  = b.ilen;
      bus.ipos  = b.ipos;
      bus.idata = b.idata;
   endtask

   task automatic setv(input int i, input string name, input beat_t b, input int onum,
                       input bit otrunc, input int ch, input int slot, input int val);
      vt[i].name = name; vt[i].b = b; vt[i].onum = onum; vt[i].otrunc = otrunc;
      vt[i].ch = ch; vt[i].slot = slot; vt[i].val = val;
   endtask

   task automatic run_stream(input int nb, input bit rnd, input string tag);
      exp_t  q[$];
      exp_t  x;
      beat_t b;
      data_t hold;
      num_t  hold_n;
      int    sent = 0, got = 0, cyc = 0;
      bit    stalled = 1'b0, acc;
      b = rand_beat();
      drive(b);
      bus.in_valid  = 1'b1;
      bus.out_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      while (got < nb && cyc < 4000) begin
         @(negedge clk);
         if (stalled) begin
            chk({tag, "_hold_valid"}, 256'(bus.out_valid), 256'(1));
            chk({tag, "_hold_onum"}, 256'(bus.onum), 256'(hold_n));
            chk({tag, "_hold_d0"}, bus.odata[0], hold[0]);
            chk({tag, "_hold_d1"}, bus.odata[1], hold[1]);
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL %s_extra: got unexpected beat, expected none", tag);
            end else begin
               x = q.pop_front();
               chk({tag, "_onum"}, 256'(bus.onum), 256'(x.onum));
               chk({tag, "_otrunc"}, 256'(bus.otrunc), 256'(x.otrunc));
               chk({tag, "_d0"}, bus.odata[0], x.odata[0]);
               chk({tag, "_d1"}, bus.odata[1], x.odata[1]);
            end
            got++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         hold    = bus.odata;
         hold_n  = bus.onum;
         acc     = bus.in_valid && bus.in_ready;
         if (acc) begin
            q.push_back(model(b));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            if (sent < nb) begin
               b = rand_beat();
               drive(b);
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = rnd ? ($urandom % 4 != 0) : ~bus.out_ready;
      end
      chk({tag, "_count"}, 256'(got), 256'(nb));
      chk({tag, "_drained"}, 256'(q.size()), 256'(0));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      beat_t b;
      exp_t  x;
      int    cyc, seen;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(mk(0, 0, 16'h0, 16'h0, 0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
      chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
      chk("rst_onum", 256'(bus.onum), 256'(0));
      chk("rst_otrunc", 256'(bus.otrunc), 256'(0));
      chk("rst_odata", bus.odata[0] | bus.odata[1], 256'(0));

      setv(0, "t1_pad", mk(4, 4, 16'h1121, 16'h1112, 0), 4, 1'b0, 0, 1, 0);
      setv(1, "t1_gather", mk(4, 4, 16'h1121, 16'h1112, 0), 4, 1'b0, 1, 2, 67);
      setv(2, "t2_n3", mk(3, 5, 16'h8888, 16'h8888, 8), 3, 1'b0, 0, 24, 0);
      setv(3, "t3_full", mk(5, 5, 16'h8888, 16'h8888, 8), 4, 1'b1, 1, 31, 96);
      setv(4, "t3_len9", mk(5, 5, 16'h9999, 16'h9999, 9), 3, 1'b1, 0, 27, 0);
      setv(5, "n_zero", mk(0, 3, 16'h1111, 16'h1111, 1), 0, 1'b0, 1, 0, 0);
      setv(6, "zero_len", mk(3, 3, 16'h0101, 16'h0201, 0), 3, 1'b0, 1, 2, 67);
      b = mk(1, 1, 16'h0001, 16'h0002, 0);
      b.idata[0][0] = 8'h80;
      setv(7, "sign_pad", b, 1, 1'b0, 0, 1, SIGNEXT ? 255 : 0);

      for (int v = 0; v < 8; v++) begin
         drive(vt[v].b);
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
         cyc = 0;
         while (!bus.out_valid && cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
         end
         x = model(vt[v].b);
         chk({vt[v].name, "_latency"}, 256'(cyc), 256'(1));
         chk({vt[v].name, "_onum"}, 256'(bus.onum), 256'(vt[v].onum));
         chk({vt[v].name, "_otrunc"}, 256'(bus.otrunc), 256'(vt[v].otrunc));
         chk({vt[v].name, "_slot"}, 256'(bus.odata[vt[v].ch][vt[v].slot]), 256'(vt[v].val));
         chk({vt[v].name, "_d0"}, bus.odata[0], x.odata[0]);
         chk({vt[v].name, "_d1"}, bus.odata[1], x.odata[1]);
         @(posedge clk);
         #1;
      end

      run_stream(10, 1'b0, "toggle");
      run_stream(300, 1'b1, "random");

      // Fill both stages with the output stalled, then reset over a pending input.
      bus.out_ready = 1'b0;
      drive(rand_beat());
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 drive(rand_beat());
      @(posedge clk);
      #1 drive(rand_beat());
      chk("full_out_valid", 256'(bus.out_valid), 256'(1));
      chk("full_in_ready", 256'(bus.in_ready), 256'(0));
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("flush_out_valid", 256'(bus.out_valid), 256'(0));
      chk("flush_in_ready", 256'(bus.in_ready), 256'(1));
      chk("flush_onum", 256'(bus.onum), 256'(0));
      chk("flush_odata", bus.odata[0] | bus.odata[1], 256'(0));
      seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1 if (bus.out_valid) seen++;
      end
      chk("flush_no_stale", 256'(seen), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
